// File: rtl/keypad_scanner.sv
// Row-scanning 4x4 keypad controller: drives one row low at a time, debounces
// the first closed key it finds and reports it once, then waits for a clean release.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic       key_valid,
  output logic [1:0] key_row,
  output logic [1:0] key_col,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CNT - 1);

  state_t      state, state_n;
  logic [1:0]  row_ptr, row_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  cand, cand_n;
  logic [3:0]  col_meta, col_s;
  logic [1:0]  low_idx;
  logic        cand_open;
  logic        accept, release_done;

  // State register, column synchronizer and the registered key report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      row_ptr   <= 2'd0;
      cnt       <= 16'd0;
      cand      <= 2'd0;
      col_meta  <= 4'b1111;
      col_s     <= 4'b1111;
      key_valid <= 1'b0;
      key_row   <= 2'd0;
      key_col   <= 2'd0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      row_ptr   <= row_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      col_meta  <= keypadCol;
      col_s     <= col_meta;
      key_valid <= accept;
      if (accept) begin
        key_row  <= row_ptr;
        key_col  <= cand;
        key_held <= 1'b1;
      end else if (!enable || release_done) begin
        key_held <= 1'b0;
      end
    end
  end

  // Next-state logic; the one counter serves as row dwell timer and as debounce timer
  always_comb begin
    state_n      = state;
    row_n        = row_ptr;
    cnt_n        = cnt;
    cand_n       = cand;
    accept       = 1'b0;
    release_done = 1'b0;
    cand_open    = col_s[cand];

    if (!col_s[0])      low_idx = 2'd0;
    else if (!col_s[1]) low_idx = 2'd1;
    else if (!col_s[2]) low_idx = 2'd2;
    else                low_idx = 2'd3;

    if (!enable) begin
      state_n = SCAN;
      row_n   = 2'd0;
      cnt_n   = 16'd0;
    end else begin
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt_n = 16'd0;
            if (col_s == 4'b1111) begin
              row_n = row_ptr + 2'd1;
            end else begin
              cand_n  = low_idx;
              state_n = DEBOUNCE;
            end
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        DEBOUNCE: begin
          if (!cand_open) begin
            if (cnt == DB_LAST) begin
              accept  = 1'b1;
              cnt_n   = 16'd0;
              state_n = PRESSED;
            end else begin
              cnt_n = cnt + 16'd1;
            end
          end else begin
            cnt_n   = 16'd0;
            row_n   = row_ptr + 2'd1;
            state_n = SCAN;
          end
        end
        PRESSED: begin
          if (cand_open) begin
            cnt_n   = 16'd0;
            state_n = RELEASE;
          end
        end
        RELEASE: begin
          if (cand_open) begin
            if (cnt == DB_LAST) begin
              release_done = 1'b1;
              cnt_n        = 16'd0;
              row_n        = row_ptr + 2'd1;
              state_n      = SCAN;
            end else begin
              cnt_n = cnt + 16'd1;
            end
          end else begin
            cnt_n   = 16'd0;
            state_n = PRESSED;
          end
        end
        default: begin
          state_n = SCAN;
          cnt_n   = 16'd0;
        end
      endcase
    end
  end

  // Row drive is released entirely while disabled or held in reset
  always_comb begin
    keypadRow = 4'b1111;
    if (enable && rst) keypadRow = ~(4'b0001 << row_ptr);
  end

endmodule
